tdc_pair_sequencer: RTL

- Controller upstream of the TDC pair-difference datapath.
- Groups the raw TDC measurement stream (dval/mlt) into ordered (A,B) pairs aligned to the clk_10k frame.
- Presents each pair to the difference stage over a valid/ready handshake.
- Detects lost, late and extra samples, drops broken pairs and resynchronises pairing on every frame start, so pair order can never slip by one sample.

---
 rtl/tdc_pair_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/tdc_pair_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tdc_pair_sequencer
//
// Sits in front of the TDC pair-difference datapath. It groups the raw
// measurement stream (dval/mlt) into ordered (A,B) pairs aligned to the
// clk_10k frame and hands each pair downstream over a valid/ready handshake.
// Lost, late and extra samples break the current pair, and pairing restarts
// on every frame start, so the A/B order can never slip by one sample.
//
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   dval, mlt           one-cycle measurement strobe and its DATA_W-bit word
//   clk_10k             frame reference, asynchronous to clk
//   pair_valid/ready    handshake for pair_a, pair_b, pair_phase
//   pair_a, pair_b      first/second sample of the pair (bit-exact)
//   pair_phase          synchronised clk_10k level when A was captured
//   busy                pair in progress (S_SECOND or S_ISSUE)
//   err_timeout         pulse: A dropped, no B within TIMEOUT cycles
//   err_resync          pulse: A dropped by a frame start
//   err_overrun         pulse: sample arrived while a pair was pending
//
// Optional build macro TDC_SEQ_STATS_EN adds saturating 16-bit counters:
//   pair_cnt            accepted handshakes
//   drop_cnt            cycles carrying at least one error pulse
// -----------------------------------------------------------------------------
module tdc_pair_sequencer #(
  parameter int DATA_W      = 37,
  parameter int TIMEOUT     = 5000,  // must be >= 2
  parameter int SYNC_STAGES = 2      // must be >= 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dval,
  input  logic [DATA_W-1:0] mlt,
  input  logic              clk_10k,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic [DATA_W-1:0] pair_a,
  output logic [DATA_W-1:0] pair_b,
  output logic              pair_phase,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_resync,
  output logic              err_overrun
`ifdef TDC_SEQ_STATS_EN
  ,
  output logic [15:0]       pair_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  typedef enum logic [1:0] {
    S_WAIT_SYNC = 2'd0,
    S_FIRST     = 2'd1,
    S_SECOND    = 2'd2,
    S_ISSUE     = 2'd3
  } state_t;

  // The timer is compared against its pre-increment value, so the timeout
  // fires on the same edge at which the timer would reach TIMEOUT-1.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 2);

  state_t              state_q, state_d;
  logic [15:0]         timer_q, timer_d;
  logic [DATA_W-1:0]   pair_a_q, pair_a_d;
  logic [DATA_W-1:0]   pair_b_q, pair_b_d;
  logic                pair_phase_q, pair_phase_d;
  logic                pair_valid_q, busy_q;
  logic                err_timeout_q, err_timeout_d;
  logic                err_resync_q, err_resync_d;
  logic                err_overrun_q, err_overrun_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   sync_lvl;
  logic                   frame_start;

  // clk_10k synchroniser and rising-edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], clk_10k};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_lvl    = sync_q[SYNC_STAGES-1];
  assign frame_start = sync_lvl & ~sync_prev_q;

  // Next-state logic: frame_start > dval > timeout inside S_SECOND
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    pair_a_d      = pair_a_q;
    pair_b_d      = pair_b_q;
    pair_phase_d  = pair_phase_q;
    err_timeout_d = 1'b0;
    err_resync_d  = 1'b0;
    err_overrun_d = 1'b0;
    case (state_q)
      S_WAIT_SYNC: begin
        if (frame_start) state_d = S_FIRST;
      end
      S_FIRST: begin
        if (dval) begin
          pair_a_d     = mlt;
          pair_phase_d = sync_lvl;
          timer_d      = '0;
          state_d      = S_SECOND;
        end
      end
      S_SECOND: begin
        timer_d = timer_q + 16'd1;
        if (frame_start) begin
          err_resync_d = 1'b1;
          timer_d      = '0;
          if (dval) begin
            // The coincident sample opens the new pair.
            pair_a_d     = mlt;
            pair_phase_d = sync_lvl;
          end else begin
            state_d = S_FIRST;
          end
        end else if (dval) begin
          pair_b_d = mlt;
          timer_d  = '0;
          state_d  = S_ISSUE;
        end else if (timer_q == TMO_LAST) begin
          err_timeout_d = 1'b1;
          timer_d       = '0;
          state_d       = S_FIRST;
        end
      end
      S_ISSUE: begin
        // A pending pair is never cancelled; extra samples are discarded.
        if (dval) err_overrun_d = 1'b1;
        if (pair_ready) state_d = S_FIRST;
      end
      default: state_d = S_WAIT_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_WAIT_SYNC;
      timer_q       <= '0;
      pair_a_q      <= '0;
      pair_b_q      <= '0;
      pair_phase_q  <= 1'b0;
      pair_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_resync_q  <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      pair_a_q      <= pair_a_d;
      pair_b_q      <= pair_b_d;
      pair_phase_q  <= pair_phase_d;
      pair_valid_q  <= (state_d == S_ISSUE);
      busy_q        <= (state_d == S_SECOND) || (state_d == S_ISSUE);
      err_timeout_q <= err_timeout_d;
      err_resync_q  <= err_resync_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign pair_valid  = pair_valid_q;
  assign pair_a      = pair_a_q;
  assign pair_b      = pair_b_q;
  assign pair_phase  = pair_phase_q;
  assign busy        = busy_q;
  assign err_timeout = err_timeout_q;
  assign err_resync  = err_resync_q;
  assign err_overrun = err_overrun_q;

`ifdef TDC_SEQ_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    sat_inc = (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  logic [15:0] pair_cnt_q, drop_cnt_q;
  logic        drop_any;

  // Counted from the next-state pulses so several errors in one cycle count once.
  assign drop_any = err_timeout_d | err_resync_d | err_overrun_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      pair_cnt_q <= sat_inc(pair_cnt_q, pair_valid_q & pair_ready);
      drop_cnt_q <= sat_inc(drop_cnt_q, drop_any);
    end
  end

  assign pair_cnt = pair_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule
